data_mem_resp: RTL and testbench
================================

# data_mem_resp

Data-memory responder on the far end of the core's load/store port. It serves `ram_read`/`ram_write` requests from the core's execute stage. Reads return a full word combinationally; byte, halfword and word writes commit on the clock edge. An on-board serial loader FSM preloads memory from a byte stream while the core is held in reset.

## Interface
- `DEPTH_WORDS`, 4096: storage depth in 32-bit words; power of two.
- `AW`, $clog2(DEPTH_WORDS): word-address width.
- `LOAD_BASE`, 0: first word index written by the loader.
- `clk`  in  1  core clock
- `rst_sync`  in  1  synchronous active-high reset
- `ram_read`  in  1  core load request
- `ram_raddr`  in  32  load byte address
- `ram_rdata`  out  32  aligned word at `ram_raddr[AW+1:2]`; 0 when `ram_read`=0
- `ram_write`  in  1  core store request
- `ram_write_width`  in  2  00 byte, 01 half, 10 word, 11 reserved
- `ram_waddr`  in  32  store byte address
- `ram_wdata`  in  32  store data, LSB-justified
- `load_start`  in  1  begin a load session
- `load_valid`  in  1  `load_byte` valid
- `load_byte`  in  8  loader data, little-endian within each word
- `load_last`  in  1  qualifies the final byte of the session
- `load_ready`  out  1  loader accepts a byte
- `load_busy`  out  1  session in progress; system holds the core in `rst_sync`
- `load_done`  out  1  one-cycle pulse at session end
- `misalign_err`  out  1  sticky misaligned-store flag

## Operation
- Clock and reset: one clock `clk`; `rst_sync` is synchronous, active-high.
- Address decode: only bits [AW+1:2] are used. Upper bits alias. No bus errors.
- Read: `ram_rdata` is the combinational array read. Byte extraction and sign extension happen in the core.
- Write lanes:
  - byte: `ram_wdata[7:0]` to lane `ram_waddr[1:0]`.
  - half: `ram_wdata[15:0]` to lanes {`ram_waddr[1]`,0}, i.e. bytes 0–1 or 2–3.
  - word: all lanes.
  - width 11: no write.
- Read and write to the same word in the same cycle: `ram_rdata` shows the pre-write contents.
- Core writes are dropped while `load_busy`=1. Core reads are still served.
- Loader FSM:
  - IDLE: on `load_start` go to LOAD. Clear `byte_cnt`, set `word_ptr`=LOAD_BASE, clear the assembly register.
  - LOAD: `load_ready`=1. Each `load_valid` byte goes to lane `byte_cnt`.
    - On the 4th byte, or on `load_last`, write the assembled word to `word_ptr` with only the received lanes enabled. Then `word_ptr`++ (wraps modulo DEPTH_WORDS) and `byte_cnt`=0.
    - `load_last` moves the FSM to DONE.
  - DONE: `load_done`=1 for one cycle, then IDLE.
- `load_start` outside IDLE is ignored. `load_valid` outside LOAD is ignored.
- `rst_sync` mid-session returns the FSM to IDLE and discards the partial assembly. Words already committed are kept.
- Memory contents are not reset.

## Timing
- Reset values: `load_ready`=0, `load_busy`=0, `load_done`=0, `misalign_err`=0, FSM=IDLE. `ram_rdata` follows `ram_read`.
- Read latency: 0 cycles (combinational). Write visible to a read on the next cycle.
- `load_busy`=1 from the cycle after `load_start` through the DONE cycle inclusive.
- Loader word commit: on the same edge that accepts the completing byte.
- `load_done`: the cycle after `load_last` is accepted.
- Loader throughput: one byte per cycle. There is no backpressure inside LOAD.

## Configuration
- `DMEM_MISALIGN_CHECK_EN` defined:
  - A half store with `ram_waddr[0]`=1, or a word store with `ram_waddr[1:0]`≠0, is suppressed.
  - `misalign_err` is set on the next edge and stays set until `rst_sync`.
- Undefined:
  - `misalign_err` is tied 0.
  - Misaligned stores ignore the offending low address bits and use the lane rules above.

## Structure
- Shared package `dmem_pkg`:
  - width codes `W_BYTE`/`W_HALF`/`W_WORD`.
  - loader state enum IDLE/LOAD/DONE.
  - byte-enable function (width, addr[1:0]) -> 4-bit mask.
- Sub-module `dmem_loader`: FSM, counters, assembly register. It produces word address, data and lane mask into a 2:1 write mux ahead of the array.
- The array and lane-write logic stay in the top.

## Test plan
- Word store 0xDEADBEEF @0x10, then read 0x10 -> `ram_rdata`=0xDEADBEEF the next cycle. Read 0x13 -> same word.
- Byte store 0xAA @0x11 over 0x00000000, then half store 0x1234 @0x12 -> read 0x10 = 0x1234AA00.
- Loader with LOAD_BASE=0: bytes 01 02 03 04 05 06 with `load_last` on 06 -> word0=0x04030201, word1 lanes 0–1 = 0x0605 and upper lanes unchanged. `load_done` pulses once, and `load_busy` falls after it.
- Core word store issued during `load_busy` -> memory unchanged. A concurrent read returns the current contents.
- With `DMEM_MISALIGN_CHECK_EN`: word store @0x22 -> no write, `misalign_err`=1, held until `rst_sync`. Without the macro: the word lands at 0x20 and the flag stays 0.
- Reset after 2 bytes of a session -> FSM IDLE, `load_busy`=0, the target word unmodified. A new `load_start` restarts at LOAD_BASE.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: store width codes, loader states and lane-mask helper
package dmem_pkg;
  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} ld_state_e;
  function automatic logic [3:0] be_mask(input logic [1:0] width, input logic [1:0] a);
    return width == W_BYTE ? 4'b0001 << a :
           width == W_HALF ? (a[1] ? 4'b1100 : 4'b0011) :
           width == W_WORD ? 4'b1111 : 4'b0000;
  endfunction
endpackage

// File: rtl/dmem_loader.sv
// dmem_loader: serial byte-stream preload FSM assembling little-endian words
module dmem_loader
  import dmem_pkg::*;
#(
  parameter int AW        = 12,
  parameter int LOAD_BASE = 0
) (
  input  logic          clk,
  input  logic          rst_sync,
  input  logic          load_start,
  input  logic          load_valid,
  input  logic [7:0]    load_byte,
  input  logic          load_last,
  output logic          load_ready,
  output logic          load_busy,
  output logic          load_done,
  output logic          ld_we,
  output logic [AW-1:0] ld_addr,
  output logic [31:0]   ld_data,
  output logic [3:0]    ld_be
);
  ld_state_e state_q, state_d;
  logic [1:0] byte_cnt_q, byte_cnt_d;
  logic [AW-1:0] word_ptr_q, word_ptr_d;
  logic [31:0] asm_q, asm_d;
  logic take, commit;
  always_comb begin
    take = state_q == LOAD && load_valid;
    commit = take && (byte_cnt_q == 2'd3 || load_last);
    ld_data = asm_q;
    ld_data[8*byte_cnt_q +: 8] = load_byte;
    ld_be = ~(4'b1110 << byte_cnt_q);
    ld_we = commit && !rst_sync;
    ld_addr = word_ptr_q;
    state_d = state_q == IDLE ? (load_start ? LOAD : IDLE) :
              state_q == LOAD ? (take && load_last ? DONE : LOAD) : IDLE;
    byte_cnt_d = state_q == IDLE || commit ? 2'd0 : take ? byte_cnt_q + 2'd1 : byte_cnt_q;
    word_ptr_d = state_q == IDLE ? AW'(LOAD_BASE) : commit ? word_ptr_q + 1'b1 : word_ptr_q;
    asm_d = state_q == IDLE || commit ? 32'h0 : take ? ld_data : asm_q;
  end
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state_q <= IDLE;
      byte_cnt_q <= 2'd0;
      word_ptr_q <= AW'(LOAD_BASE);
      asm_q <= 32'h0;
    end else begin
      state_q <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_ptr_q <= word_ptr_d;
      asm_q <= asm_d;
    end
  end
  assign load_ready = state_q == LOAD;
  assign load_busy = state_q != IDLE;
  assign load_done = state_q == DONE;
endmodule

// File: rtl/data_mem_resp.sv
// data_mem_resp: core data memory with lane writes and serial preloader; DMEM_MISALIGN_CHECK_EN suppresses misaligned stores
module data_mem_resp
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS),
  parameter int LOAD_BASE   = 0
) (
  input  logic        clk,
  input  logic        rst_sync,
  input  logic        ram_read,
  input  logic [31:0] ram_raddr,
  output logic [31:0] ram_rdata,
  input  logic        ram_write,
  input  logic [1:0]  ram_write_width,
  input  logic [31:0] ram_waddr,
  input  logic [31:0] ram_wdata,
  input  logic        load_start,
  input  logic        load_valid,
  input  logic [7:0]  load_byte,
  input  logic        load_last,
  output logic        load_ready,
  output logic        load_busy,
  output logic        load_done,
  output logic        misalign_err
);
  logic [31:0] mem [DEPTH_WORDS];
  logic ld_we, mis, core_we, we, misalign_err_q, misalign_err_d, unused;
  logic [AW-1:0] ld_addr, wa;
  logic [31:0] ld_data, core_data, wd;
  logic [3:0] ld_be, core_be, be;
  dmem_loader #(.AW(AW), .LOAD_BASE(LOAD_BASE)) u_loader (
    .clk(clk), .rst_sync(rst_sync), .load_start(load_start), .load_valid(load_valid),
    .load_byte(load_byte), .load_last(load_last), .load_ready(load_ready),
    .load_busy(load_busy), .load_done(load_done), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_be(ld_be)
  );
  always_comb begin
    core_be = be_mask(ram_write_width, ram_waddr[1:0]);
    core_data = ram_write_width == W_BYTE ? {4{ram_wdata[7:0]}} :
                ram_write_width == W_HALF ? {2{ram_wdata[15:0]}} : ram_wdata;
`ifdef DMEM_MISALIGN_CHECK_EN
    mis = ram_write && !load_busy &&
          ((ram_write_width == W_HALF && ram_waddr[0]) ||
           (ram_write_width == W_WORD && ram_waddr[1:0] != 2'b00));
`else
    mis = 1'b0;
`endif
    core_we = ram_write && !load_busy && !mis;
    we = ld_we || core_we;
    wa = ld_we ? ld_addr : ram_waddr[AW+1:2];
    wd = ld_we ? ld_data : core_data;
    be = ld_we ? ld_be : core_be;
    misalign_err_d = misalign_err_q || mis;
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[wa][8*i +: 8] <= wd[8*i +: 8];
  end
  always_ff @(posedge clk) begin
    if (rst_sync) misalign_err_q <= 1'b0;
    else misalign_err_q <= misalign_err_d;
  end
  assign misalign_err = misalign_err_q;
  assign ram_rdata = ram_read ? mem[ram_raddr[AW+1:2]] : 32'h0;
  assign unused = ^{ram_raddr[31:AW+2], ram_raddr[1:0], ram_waddr[31:AW+2]};
endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp: random and directed checks of data_mem_resp against a word-level model
module tb_data_mem_resp;
  localparam int WIN = 64;
`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_sync, ram_read, ram_write, load_start, load_valid, load_last;
  logic load_ready, load_busy, load_done, misalign_err;
  logic [31:0] ram_raddr, ram_rdata, ram_waddr, ram_wdata;
  logic [1:0] ram_write_width;
  logic [7:0] load_byte;
  int checks = 0, errors = 0;
  logic [31:0] m [WIN];
  bit known [WIN];
  int lst = 0, bcnt = 0, wptr = 0;
  logic [7:0] lb [4];
  bit mflag = 1'b0;
  data_mem_resp dut (
    .clk(clk), .rst_sync(rst_sync), .ram_read(ram_read), .ram_raddr(ram_raddr),
    .ram_rdata(ram_rdata), .ram_write(ram_write), .ram_write_width(ram_write_width),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .load_start(load_start),
    .load_valid(load_valid), .load_byte(load_byte), .load_last(load_last),
    .load_ready(load_ready), .load_busy(load_busy), .load_done(load_done),
    .misalign_err(misalign_err)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    int ri, wi, n, base;
    bit bad;
    ri = int'(ram_raddr[7:2]);
    if (!ram_read) chk("rdata_idle", ram_rdata, 32'h0);
    else if (known[ri]) chk("rdata", ram_rdata, m[ri]);
    chk("load_ready", 32'(load_ready), 32'(lst == 1));
    chk("load_busy", 32'(load_busy), 32'(lst != 0));
    chk("load_done", 32'(load_done), 32'(lst == 2));
    chk("misalign_err", 32'(misalign_err), 32'(mflag));
    if (ram_write && lst == 0 && ram_write_width != 2'b11) begin
      wi = int'(ram_waddr[7:2]);
      n = ram_write_width == 2'b00 ? 1 : ram_write_width == 2'b01 ? 2 : 4;
      base = n == 1 ? int'(ram_waddr[1:0]) : n == 2 ? 2 * int'(ram_waddr[1]) : 0;
      bad = MIS && ((n == 2 && ram_waddr[0]) || (n == 4 && ram_waddr[1:0] != 2'b00));
      if (bad) mflag = 1'b1;
      else begin
        for (int k = 0; k < n; k++) m[wi][8*(base+k) +: 8] = ram_wdata[8*k +: 8];
        if (n == 4) known[wi] = 1'b1;
      end
    end
    if (rst_sync) begin
      lst = 0;
      mflag = 1'b0;
    end else if (lst == 0) begin
      if (load_start) begin
        lst = 1;
        bcnt = 0;
        wptr = 0;
      end
    end else if (lst == 1) begin
      if (load_valid) begin
        lb[bcnt] = load_byte;
        if (bcnt == 3 || load_last) begin
          for (int k = 0; k <= bcnt; k++) m[wptr][8*k +: 8] = lb[k];
          wptr = (wptr + 1) % WIN;
          bcnt = 0;
        end else bcnt++;
        if (load_last) lst = 2;
      end
    end else lst = 0;
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
    ram_write = 1'b1;
    ram_write_width = w;
    ram_waddr = a;
    ram_wdata = d;
    cyc();
    ram_write = 1'b0;
  endtask
  task automatic rdchk(input string name, input logic [31:0] a, input logic [31:0] exp);
    ram_read = 1'b1;
    ram_raddr = a;
    #1;
    chk(name, ram_rdata, exp);
    cyc();
    ram_read = 1'b0;
  endtask
  task automatic send(input logic [7:0] b, input logic last);
    load_valid = 1'b1;
    load_byte = b;
    load_last = last;
    cyc();
    load_valid = 1'b0;
    load_last = 1'b0;
  endtask
  task automatic start();
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
  endtask
  function automatic logic [31:0] ra();
    logic [31:0] r;
    r = $urandom;
    r[13:8] = 6'h0;
    return r;
  endfunction
  initial begin
    rst_sync = 1'b1;
    {ram_read, ram_write, load_start, load_valid, load_last} = '0;
    ram_raddr = 32'h0;
    ram_waddr = 32'h0;
    ram_wdata = 32'h0;
    ram_write_width = 2'b00;
    load_byte = 8'h0;
    repeat (2) cyc();
    chk("rst_ready", 32'(load_ready), 32'h0);
    chk("rst_busy", 32'(load_busy), 32'h0);
    chk("rst_done", 32'(load_done), 32'h0);
    chk("rst_misalign", 32'(misalign_err), 32'h0);
    chk("rst_rdata", ram_rdata, 32'h0);
    rst_sync = 1'b0;
    for (int i = 0; i < WIN; i++) wr(2'b10, 32'(i * 4), $urandom);
    wr(2'b10, 32'h10, 32'hDEADBEEF);
    rdchk("word_rd", 32'h10, 32'hDEADBEEF);
    rdchk("word_rd_off3", 32'h13, 32'hDEADBEEF);
    rdchk("word_rd_alias", 32'hABC00010, 32'hDEADBEEF);
    wr(2'b10, 32'h10, 32'h0);
    wr(2'b00, 32'h11, 32'h000000AA);
    wr(2'b01, 32'h12, 32'h00001234);
    rdchk("byte_half", 32'h10, 32'h1234AA00);
    wr(2'b11, 32'h10, 32'hFFFFFFFF);
    rdchk("width_rsvd", 32'h10, 32'h1234AA00);
    wr(2'b10, 32'h4, 32'hCAFEF00D);
    start();
    chk("ld_busy_start", 32'(load_busy), 32'h1);
    for (int i = 1; i <= 6; i++) send(8'(i), i == 6);
    chk("ld_done_pulse", 32'(load_done), 32'h1);
    chk("ld_busy_done", 32'(load_busy), 32'h1);
    cyc();
    chk("ld_done_clr", 32'(load_done), 32'h0);
    chk("ld_busy_clr", 32'(load_busy), 32'h0);
    rdchk("ld_word0", 32'h0, 32'h04030201);
    rdchk("ld_word1", 32'h4, 32'hCAFE0605);
    wr(2'b10, 32'h8, 32'h87654321);
    start();
    ram_write = 1'b1;
    ram_write_width = 2'b10;
    ram_waddr = 32'h8;
    ram_wdata = 32'h12345678;
    ram_read = 1'b1;
    ram_raddr = 32'h8;
    #1;
    chk("busy_rd", ram_rdata, 32'h87654321);
    send(8'h77, 1'b1);
    ram_write = 1'b0;
    ram_read = 1'b0;
    cyc();
    rdchk("busy_wr_drop", 32'h8, 32'h87654321);
    rdchk("busy_ld_word", 32'h0, 32'h04030277);
    wr(2'b10, 32'h20, 32'h11111111);
    wr(2'b10, 32'h22, 32'h55667788);
    if (MIS) begin
      rdchk("mis_suppress", 32'h20, 32'h11111111);
      chk("mis_set", 32'(misalign_err), 32'h1);
      repeat (3) cyc();
      chk("mis_hold", 32'(misalign_err), 32'h1);
      rst_sync = 1'b1;
      cyc();
      rst_sync = 1'b0;
      chk("mis_rst", 32'(misalign_err), 32'h0);
    end else begin
      rdchk("mis_lands", 32'h20, 32'h55667788);
      chk("mis_off", 32'(misalign_err), 32'h0);
    end
    wr(2'b10, 32'h0, 32'hA5A5A5A5);
    start();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    rst_sync = 1'b1;
    cyc();
    rst_sync = 1'b0;
    chk("rst_mid_busy", 32'(load_busy), 32'h0);
    chk("rst_mid_ready", 32'(load_ready), 32'h0);
    rdchk("rst_mid_word", 32'h0, 32'hA5A5A5A5);
    start();
    for (int i = 1; i <= 4; i++) send(8'h30 + 8'(i), i == 4);
    cyc();
    rdchk("restart_word0", 32'h0, 32'h34333231);
    rdchk("restart_word1", 32'h4, 32'hCAFE0605);
    for (int c = 0; c < 3000; c++) begin
      rst_sync = $urandom_range(399) == 0;
      ram_read = 1'($urandom);
      ram_raddr = ra();
      ram_write = 1'($urandom);
      ram_write_width = 2'($urandom);
      ram_waddr = ra();
      ram_wdata = $urandom;
      load_start = $urandom_range(29) == 0;
      load_valid = $urandom_range(2) != 0;
      load_last = $urandom_range(4) == 0;
      load_byte = 8'($urandom);
      cyc();
    end
    {rst_sync, ram_read, ram_write, load_start, load_valid, load_last} = '0;
    repeat (2) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
